// File: rtl/wrr_arb.sv
// wrr_arb: weighted round-robin arbiter with registered one-hot grant and per-requester burst quota.
// Define WRR_ARB_LOCK_EN to add lock_i, which holds the current owner past its quota.
module wrr_arb #(
  parameter int RWID = 4,
  parameter int WWID = 4,
  parameter int IDW  = (RWID > 1) ? $clog2(RWID) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef WRR_ARB_LOCK_EN
  input  logic                 lock_i,
`endif
  input  logic [RWID-1:0]      req_i,
  input  logic [RWID*WWID-1:0] weight_i,
  output logic [RWID-1:0]      gnt_o,
  output logic [IDW-1:0]       gnt_id_o,
  output logic                 gnt_vld_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [IDW-1:0] ptr, ptr_n, win, id_n;
  logic [WWID-1:0] cnt, cnt_n;
  logic [RWID-1:0] gnt_n;
  logic hit, grant, lock;
`ifdef WRR_ARB_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif
  assign gnt_vld_o = |gnt_o;
  // circular first-set search starting at ptr; ptr is always owner+1, so this also skips past the owner
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int i = 0; i < RWID; i++)
      if (!hit && req_i[(int'(ptr) + i) % RWID]) begin
        hit = 1'b1;
        win = IDW'((int'(ptr) + i) % RWID);
      end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    gnt_n = gnt_o;
    id_n = gnt_id_o;
    grant = 1'b0;
    if (state == IDLE)
      grant = hit;
    else if (req_i[gnt_id_o] && (cnt != '0 || lock))
      cnt_n = (cnt != '0) ? cnt - WWID'(1) : cnt;
    else if (hit)
      grant = 1'b1;
    else begin
      state_n = IDLE;
      gnt_n = '0;
    end
    if (grant) begin
      state_n = GRANT;
      ptr_n = (win == IDW'(RWID - 1)) ? '0 : win + IDW'(1);
      cnt_n = weight_i[win*WWID +: WWID];
      gnt_n = RWID'(1) << win;
      id_n = win;
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      gnt_o <= '0;
      gnt_id_o <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      gnt_o <= gnt_n;
      gnt_id_o <= id_n;
    end
endmodule

// File: tb/tb_wrr_arb.sv
// tb_wrr_arb: table-driven directed vectors for wrr_arb plus fairness and lock sequences.
module tb_wrr_arb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lock = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] weight = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic gnt_vld;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [15:0] w;
    logic [3:0] gnt;
    logic [1:0] id;
  } vec_t;
  vec_t vq[$];

  wrr_arb dut (
    .clk(clk),
    .reset(reset),
`ifdef WRR_ARB_LOCK_EN
    .lock_i(lock),
`endif
    .req_i(req),
    .weight_i(weight),
    .gnt_o(gnt),
    .gnt_id_o(gnt_id),
    .gnt_vld_o(gnt_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic [15:0] w);
    reset = r;
    req = q;
    weight = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // reset with requests pending
    vq.push_back('{1'b0, 4'hF, 16'h0000, 4'b0000, 2'd0});
    vq.push_back('{1'b0, 4'hF, 16'h0000, 4'b0000, 2'd0});
    // plain round robin, weights 0
    vq.push_back('{1'b1, 4'hF, 16'h0000, 4'b0001, 2'd0});
    vq.push_back('{1'b1, 4'hF, 16'h0000, 4'b0010, 2'd1});
    vq.push_back('{1'b1, 4'hF, 16'h0000, 4'b0100, 2'd2});
    vq.push_back('{1'b1, 4'hF, 16'h0000, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'hF, 16'h0000, 4'b0001, 2'd0});
    vq.push_back('{1'b1, 4'hF, 16'h0000, 4'b0010, 2'd1});
    vq.push_back('{1'b1, 4'hF, 16'h0000, 4'b0100, 2'd2});
    vq.push_back('{1'b1, 4'hF, 16'h0000, 4'b1000, 2'd3});
    // weighted {3,0,1,2}: req0 x3, req1 x2, req2 x1, req3 x4
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b0001, 2'd0});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b0001, 2'd0});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b0001, 2'd0});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b0010, 2'd1});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b0010, 2'd1});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b0100, 2'd2});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'hF, 16'h3012, 4'b0001, 2'd0});
    // early release, back-to-back handover, then idle holding last id
    vq.push_back('{1'b0, 4'h0, 16'h0005, 4'b0000, 2'd0});
    vq.push_back('{1'b1, 4'h1, 16'h0005, 4'b0001, 2'd0});
    vq.push_back('{1'b1, 4'h1, 16'h0005, 4'b0001, 2'd0});
    vq.push_back('{1'b1, 4'h4, 16'h0005, 4'b0100, 2'd2});
    vq.push_back('{1'b1, 4'h0, 16'h0005, 4'b0000, 2'd2});
    vq.push_back('{1'b1, 4'h0, 16'h0005, 4'b0000, 2'd2});
    // single requester re-granted without gap, then wrap to req0
    vq.push_back('{1'b1, 4'h8, 16'h1000, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'h8, 16'h1000, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'h8, 16'h1000, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'h8, 16'h1000, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'h8, 16'h1000, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'h8, 16'h1000, 4'b1000, 2'd3});
    vq.push_back('{1'b1, 4'h9, 16'h1000, 4'b0001, 2'd0});
    vq.push_back('{1'b1, 4'h9, 16'h1000, 4'b1000, 2'd3});
    // mid-burst reset; weight change mid-burst is ignored; ptr back to 0 afterwards
    vq.push_back('{1'b0, 4'h0, 16'h0003, 4'b0000, 2'd0});
    vq.push_back('{1'b1, 4'h1, 16'h0003, 4'b0001, 2'd0});
    vq.push_back('{1'b1, 4'h1, 16'h0000, 4'b0001, 2'd0});
    vq.push_back('{1'b0, 4'h1, 16'h0003, 4'b0000, 2'd0});
    vq.push_back('{1'b1, 4'h2, 16'h0003, 4'b0010, 2'd1});

    #1;
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].req, vq[i].w);
      chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(vq[i].gnt));
      chk($sformatf("row%0d id", i), 32'(gnt_id), 32'(vq[i].id));
      chk($sformatf("row%0d vld", i), 32'(gnt_vld), 32'(vq[i].gnt != 4'b0000));
    end

    // fairness: req3 waits for req0 (3), req1 (2), req2 (1) cycles, granted on edge 7
    step(1'b0, 4'h0, 16'h3012);
    n = 0;
    for (int c = 1; c <= 12 && n == 0; c++) begin
      step(1'b1, 4'hF, 16'h3012);
      if (gnt[3]) n = c;
    end
    chk("fair_wait_req3", 32'(n), 32'd7);

`ifdef WRR_ARB_LOCK_EN
    step(1'b0, 4'h0, 16'h0000);
    lock = 1'b1;
    step(1'b1, 4'h3, 16'h0000);
    chk("lock_first", 32'(gnt), 32'h1);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 4'h3, 16'h0000);
      chk($sformatf("lock_hold%0d", c), 32'(gnt), 32'h1);
    end
    lock = 1'b0;
    step(1'b1, 4'h3, 16'h0000);
    chk("lock_drop", 32'(gnt), 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
